// File: rtl/icebreaker_gpio_pkg.sv
// Shared constants for the icebreaker GPIO peripheral: register offsets, debounce sizing, address decode.
// Latency: n/a (declarations only). Backpressure: n/a.
// Debounce constants are only consumed when ICEBREAKER_GPIO_DEBOUNCE_EN is defined.
package icebreaker_gpio_pkg;

    localparam logic [7:0] OFF_IN       = 8'h00;
    localparam logic [7:0] OFF_OUT      = 8'h04;
    localparam logic [7:0] OFF_DIR      = 8'h08;
    localparam logic [7:0] OFF_RISE_EN  = 8'h0C;
    localparam logic [7:0] OFF_FALL_EN  = 8'h10;
    localparam logic [7:0] OFF_IRQ_PEND = 8'h14;
    localparam logic [7:0] OFF_DBNC     = 8'h18;

    localparam int         DBNC_W      = 16;
    localparam logic [1:0] DBNC_THRESH = 2'd3;

    typedef enum logic [2:0] {
        SEL_IN,
        SEL_OUT,
        SEL_DIR,
        SEL_RISE,
        SEL_FALL,
        SEL_PEND,
        SEL_DBNC,
        SEL_NONE
    } reg_sel_e;

    // Only word address bits [7:2] select a register; byte lanes are ignored.
    function automatic reg_sel_e decode(input logic [5:0] word);
        case ({word, 2'b00})
            OFF_IN:       return SEL_IN;
            OFF_OUT:      return SEL_OUT;
            OFF_DIR:      return SEL_DIR;
            OFF_RISE_EN:  return SEL_RISE;
            OFF_FALL_EN:  return SEL_FALL;
            OFF_IRQ_PEND: return SEL_PEND;
            OFF_DBNC:     return SEL_DBNC;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/icebreaker_gpio_input.sv
// Pad input conditioning: 2-flop synchronizer, optional debounce when ICEBREAKER_GPIO_DEBOUNCE_EN is defined.
// Latency: 2 cycles pad->stable (debounce bypassed or absent); debounce adds DBNC_THRESH prescaler ticks.
// Backpressure: none, free-running every cycle.
module icebreaker_gpio_input
    import icebreaker_gpio_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      pin_in,
`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
    input  logic [DBNC_W-1:0] dbnc,
    input  logic              dbnc_wr,
`endif
    output logic [N-1:0]      stable
);

    logic [N-1:0] meta;
    logic [N-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pin_in;
            sync <= meta;
        end
    end

`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
    logic [DBNC_W-1:0] presc;
    logic              tick;
    logic [N-1:0]      stable_q;
    logic [1:0]        cnt [N];

    assign tick = (presc == dbnc);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            stable_q <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else begin
            if (dbnc_wr || tick) presc <= '0;
            else                 presc <= presc + DBNC_W'(1);
            for (int i = 0; i < N; i++) begin
                // Tracking sync while bypassed keeps stable continuous when debounce is enabled.
                if (dbnc == '0) begin
                    stable_q[i] <= sync[i];
                    cnt[i]      <= '0;
                end else if (dbnc_wr) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (sync[i] != stable_q[i]) begin
                        if (cnt[i] == DBNC_THRESH - 2'd1) begin
                            stable_q[i] <= sync[i];
                            cnt[i]      <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 2'd1;
                        end
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign stable = (dbnc == '0) ? sync : stable_q;
`else
    assign stable = sync;
`endif

endmodule

// File: rtl/icebreaker_gpio_lite.sv
// Memory-mapped GPIO: direction/output regs, synchronized input, edge IRQ capture (W1C); DBNC reg with ICEBREAKER_GPIO_DEBOUNCE_EN.
// Latency: write visible next cycle, read data registered one cycle after gpio_en, pad->IRQ_PEND 3 cycles.
// Backpressure: none, accepts one access every cycle without stalling.
module icebreaker_gpio_lite
    import icebreaker_gpio_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  gpio_addr,
    input  logic [31:0]  gpio_wr_data,
    input  logic         gpio_en,
    input  logic         gpio_wr_en,
    output logic [31:0]  gpio_rd_data,
    input  logic [N-1:0] pin_in,
    output logic [N-1:0] pin_out,
    output logic [N-1:0] pin_oe,
    output logic         irq
);

    logic [N-1:0] out_r;
    logic [N-1:0] dir_r;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] pend;
    logic [N-1:0] prev;
    logic [N-1:0] stable;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] w1c;
    logic [N-1:0] wr_bits;
    logic [31:0]  rd_mux;
    logic         wr;
    logic         rd;
    reg_sel_e     sel;
    logic         unused_bits;

    assign sel     = decode(gpio_addr[7:2]);
    assign wr      = gpio_en & gpio_wr_en;
    assign rd      = gpio_en & ~gpio_wr_en;
    assign wr_bits = gpio_wr_data[N-1:0];
    assign w1c     = (wr && sel == SEL_PEND) ? wr_bits : '0;
    assign rise    = stable & ~prev & rise_en;
    assign fall    = ~stable & prev & fall_en;

    assign unused_bits = ^{gpio_addr[31:8], gpio_addr[1:0], gpio_wr_data};

`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc_r;
    logic              dbnc_wr;

    assign dbnc_wr = wr && (sel == SEL_DBNC);

    always_ff @(posedge clk) begin
        if (rst)          dbnc_r <= '0;
        else if (dbnc_wr) dbnc_r <= gpio_wr_data[DBNC_W-1:0];
    end
`endif

    icebreaker_gpio_input #(.N(N)) u_input (
        .clk     (clk),
        .rst     (rst),
        .pin_in  (pin_in),
`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
        .dbnc    (dbnc_r),
        .dbnc_wr (dbnc_wr),
`endif
        .stable  (stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= '0;
            dir_r   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
            prev    <= '0;
        end else begin
            prev <= stable;
            // A new edge event overrides a W1C of the same bit in the same cycle.
            pend <= (pend & ~w1c) | rise | fall;
            if (wr) begin
                case (sel)
                    SEL_OUT:  out_r   <= wr_bits;
                    SEL_DIR:  dir_r   <= wr_bits;
                    SEL_RISE: rise_en <= wr_bits;
                    SEL_FALL: fall_en <= wr_bits;
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_IN:   rd_mux[N-1:0] = stable;
            SEL_OUT:  rd_mux[N-1:0] = out_r;
            SEL_DIR:  rd_mux[N-1:0] = dir_r;
            SEL_RISE: rd_mux[N-1:0] = rise_en;
            SEL_FALL: rd_mux[N-1:0] = fall_en;
            SEL_PEND: rd_mux[N-1:0] = pend;
`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
            SEL_DBNC: rd_mux[DBNC_W-1:0] = dbnc_r;
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)     gpio_rd_data <= '0;
        else if (rd) gpio_rd_data <= rd_mux;
    end

    assign pin_out = out_r;
    assign pin_oe  = dir_r;
    assign irq     = |pend;

endmodule

// File: tb/tb_icebreaker_gpio_lite.sv
// Bench for icebreaker_gpio_lite: scoreboard of read data against a register-level model, plus pin/irq checks.
// The debounce scenario runs only when ICEBREAKER_GPIO_DEBOUNCE_EN is defined.
module tb_icebreaker_gpio_lite;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_wr_data;
    logic        gpio_en;
    logic        gpio_wr_en;
    logic [31:0] gpio_rd_data;
    logic [7:0]  pin_in;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic        irq;

    always #5 clk = ~clk;

    icebreaker_gpio_lite #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_addr    (gpio_addr),
        .gpio_wr_data (gpio_wr_data),
        .gpio_en      (gpio_en),
        .gpio_wr_en   (gpio_wr_en),
        .gpio_rd_data (gpio_rd_data),
        .pin_in       (pin_in),
        .pin_out      (pin_out),
        .pin_oe       (pin_oe),
        .irq          (irq)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    // Register-level model of the peripheral's architectural state.
    logic [7:0]  m_out, m_dir, m_re, m_fe, m_pend, m_pin, m_in;
    logic [15:0] m_dbnc;

    logic [7:0]  offs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h40, 8'hFC};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_re = '0; m_fe = '0; m_pend = '0; m_dbnc = '0;
    endtask

    function automatic logic [31:0] model_rd(input logic [7:0] off);
        case (off)
            8'h00:   return {24'd0, m_in};
            8'h04:   return {24'd0, m_out};
            8'h08:   return {24'd0, m_dir};
            8'h0C:   return {24'd0, m_re};
            8'h10:   return {24'd0, m_fe};
            8'h14:   return {24'd0, m_pend};
`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
            8'h18:   return {16'd0, m_dbnc};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_addr(input logic [7:0] off);
        logic [31:0] r;
        r = $urandom();
        gpio_addr = {24'h000010, off[7:2], r[1:0]};
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic bus_wr(input logic [7:0] off, input logic [31:0] data);
        set_addr(off);
        gpio_wr_data = data;
        gpio_en      = 1'b1;
        gpio_wr_en   = 1'b1;
        case (off)
            8'h04: m_out  = data[7:0];
            8'h08: m_dir  = data[7:0];
            8'h0C: m_re   = data[7:0];
            8'h10: m_fe   = data[7:0];
            8'h14: m_pend = m_pend & ~data[7:0];
`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
            8'h18: m_dbnc = data[15:0];
`endif
            default: ;
        endcase
        @(negedge clk);
        gpio_en    = 1'b0;
        gpio_wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] off);
        set_addr(off);
        gpio_wr_data = $urandom();
        gpio_en      = 1'b1;
        gpio_wr_en   = 1'b0;
        exp_q.push_back(model_rd(off));
        @(negedge clk);
        gpio_en = 1'b0;
    endtask

    // Pads change, then enough idle cycles for sync + edge capture to settle.
    task automatic pin_change(input logic [7:0] v);
        m_pend = m_pend | (v & ~m_pin & m_re) | (~v & m_pin & m_fe);
        m_pin  = v;
        m_in   = v;
        pin_in = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_pins();
        chk("pin_out", {24'd0, pin_out}, {24'd0, m_out});
        chk("pin_oe",  {24'd0, pin_oe},  {24'd0, m_dir});
        chk("irq",     {31'd0, irq},     {31'd0, |m_pend});
    endtask

    // Monitor: a read accepted at a posedge is checked at the following negedge.
    initial begin
        logic rd_seen;
        forever begin
            @(posedge clk);
            rd_seen = gpio_en & ~gpio_wr_en & ~rst;
            @(negedge clk);
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got %h, expected no read", gpio_rd_data);
                end else begin
                    chk("rd_data", gpio_rd_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        rst          = 1'b1;
        gpio_addr    = '0;
        gpio_wr_data = '0;
        gpio_en      = 1'b0;
        gpio_wr_en   = 1'b0;
        pin_in       = '0;
        m_pin        = '0;
        m_in         = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_pins();
        chk("rd_reset", gpio_rd_data, 32'd0);
        rst = 1'b0;

        bus_rd(8'h04);
        bus_rd(8'h08);
        bus_rd(8'h14);

        bus_wr(8'h04, 32'h0000_00A5);
        chk_pins();
        bus_wr(8'h08, 32'h0000_00F0);
        chk_pins();
        bus_rd(8'h04);
        bus_wr(8'h10, 32'h0);
        chk("rd_hold", gpio_rd_data, 32'h0000_00A5);

        // Rising edge on pin 0: pending must appear exactly three edges after the pad change.
        bus_wr(8'h0C, 32'h01);
        pin_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        chk("irq_t2", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_t3", {31'd0, irq}, 32'd1);
        m_pin = 8'h01; m_in = 8'h01; m_pend = m_pend | 8'h01;
        bus_rd(8'h14);
        bus_wr(8'h14, 32'h01);
        chk_pins();
        bus_rd(8'h14);
        bus_rd(8'h00);

        // Falling edge on pin 1 collides with a W1C of bit 1: the event wins.
        bus_wr(8'h10, 32'h02);
        pin_change(8'h03);
        pin_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus_wr(8'h14, 32'h02);
        m_pin = 8'h01; m_in = 8'h01; m_pend = m_pend | 8'h02;
        chk_pins();
        bus_rd(8'h14);
        bus_wr(8'h14, 32'hFF);
        chk_pins();

        // Unmapped offsets and the read-only IN register.
        bus_rd(8'h40);
        bus_wr(8'h40, 32'hFFFF_FFFF);
        bus_wr(8'h00, 32'hFFFF_FFFF);
        bus_rd(8'h04);
        bus_rd(8'h08);
        bus_rd(8'h0C);
        bus_rd(8'h10);
        bus_rd(8'h14);
        bus_rd(8'h00);
        chk_pins();

        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 2);
            case (op)
                0: begin
                    bus_wr(offs[$urandom_range(0, 8)], $urandom());
                    chk_pins();
                end
                1: bus_rd(offs[$urandom_range(0, 8)]);
                default: begin
                    pin_change(8'($urandom_range(0, 255)));
                    chk_pins();
                end
            endcase
        end

        // Reset in the middle of traffic returns every register to zero.
        bus_wr(8'h04, 32'h5A);
        bus_rd(8'h04);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk_pins();
        chk("rd_after_rst", gpio_rd_data, 32'd0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) bus_rd(offs[i]);
        chk_pins();

`ifdef ICEBREAKER_GPIO_DEBOUNCE_EN
        pin_change(8'h00);
        bus_wr(8'h18, 32'd4);
        bus_rd(8'h18);
        // Glitch lasting two prescaler ticks must be filtered out.
        pin_in = 8'h04;
        repeat (10) @(negedge clk);
        pin_in = 8'h00;
        repeat (20) @(negedge clk);
        bus_rd(8'h00);
        pin_in = 8'h04;
        repeat (40) @(negedge clk);
        m_pin = 8'h04;
        m_in  = 8'h04;
        bus_rd(8'h00);
        bus_wr(8'h18, 32'd0);
        chk_pins();
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
